step_pulse_shaper: RTL and testbench

Downstream stage of the S-curve step generator. It consumes that generator's drv_step/drv_dir/drv_bypass outputs and queues each step with its direction. It re-emits each step to the external stepper driver with guaranteed direction-setup, step-high and step-low times. It also keeps a signed absolute position count for firmware readback.

---
 rtl/step_pulse_shaper_if.sv | 43 ++++
 rtl/step_pulse_shaper.sv | 227 ++++++++++++++++++++++
 tb/tb_step_pulse_shaper.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_pulse_shaper_if.sv
// Bundle between the S-curve generator, the pulse shaper and firmware.
// STEP_PULSE_SHAPER_SOFT_LIMIT_EN adds the soft position limit signals.
interface step_pulse_shaper_if #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned POS_WIDTH  = 32
);
  logic                        step_i;
  logic                        dir_i;
  logic                        bypass_i;
  logic                        clr_i;
  logic                        step_o;
  logic                        dir_o;
  logic                        bypass_o;
  logic signed [POS_WIDTH-1:0] position_o;
  logic [DEPTH_LOG2:0]         pending_o;
  logic                        overflow_o;
  logic                        busy_o;
`ifdef STEP_PULSE_SHAPER_SOFT_LIMIT_EN
  logic signed [POS_WIDTH-1:0] pos_min_i;
  logic signed [POS_WIDTH-1:0] pos_max_i;
  logic                        limit_hit_o;
`endif

  // Generator / firmware side
  modport master (
    output step_i, dir_i, bypass_i, clr_i,
`ifdef STEP_PULSE_SHAPER_SOFT_LIMIT_EN
    output pos_min_i, pos_max_i,
    input  limit_hit_o,
`endif
    input  step_o, dir_o, bypass_o, position_o, pending_o, overflow_o, busy_o
  );

  // Shaper side
  modport slave (
    input  step_i, dir_i, bypass_i, clr_i,
`ifdef STEP_PULSE_SHAPER_SOFT_LIMIT_EN
    input  pos_min_i, pos_max_i,
    output limit_hit_o,
`endif
    output step_o, dir_o, bypass_o, position_o, pending_o, overflow_o, busy_o
  );
endinterface

// File: rtl/step_pulse_shaper.sv
// Step pulse shaper: queues generator steps and re-emits them with guaranteed
// direction-setup, step-high and step-low times; tracks absolute position.
// Optional feature macro: STEP_PULSE_SHAPER_SOFT_LIMIT_EN (soft position limits).
module step_pulse_shaper #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned HIGH_CYC   = 4,
  parameter int unsigned LOW_CYC    = 4,
  parameter int unsigned DIR_SETUP  = 8,
  parameter int unsigned POS_WIDTH  = 32
) (
  input logic              clk_i,
  input logic              reset_n,
  step_pulse_shaper_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned TMR_W = 8;
  localparam logic [TMR_W-1:0] HIGH_LOAD  = TMR_W'(HIGH_CYC - 1);
  localparam logic [TMR_W-1:0] LOW_LOAD   = TMR_W'(LOW_CYC - 1);
  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(DIR_SETUP - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t                 state;
  logic [TMR_W-1:0]       timer;
  logic                   step_q;
  logic                   dir_q;
  logic                   bypass_q;
  logic                   busy_q;
  logic                   overflow_q;
  logic signed [POS_WIDTH-1:0] position_q;

  logic                   step_s1, step_s2, step_s3;
  logic                   dir_s1, dir_s2;

  logic [DEPTH-1:0]       fifo_mem;
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [CNT_W-1:0]       count;

  logic                   rise_c;
  logic                   empty_c;
  logic                   head_c;
  logic                   issue_pop_c;
  logic                   limit_drop_c;
  logic                   pop_c;
  logic                   push_ok_c;
  logic                   drop_c;
  logic                   idle_nxt_c;
  logic [CNT_W-1:0]       count_nxt_c;

`ifdef STEP_PULSE_SHAPER_SOFT_LIMIT_EN
  logic                   limit_hit_q;
`endif

  // Queue/FSM handshake decode shared by the sequential blocks
  always_comb begin
    rise_c       = step_s2 & ~step_s3;
    empty_c      = (count == '0);
    head_c       = fifo_mem[rd_ptr];
    issue_pop_c  = (state == HIGH) && (timer == '0);
    limit_drop_c = 1'b0;
`ifdef STEP_PULSE_SHAPER_SOFT_LIMIT_EN
    // Compare before stepping so the check itself cannot wrap
    if ((state == IDLE) && !empty_c) begin
      limit_drop_c = head_c ? (position_q >= bus.pos_max_i)
                            : (position_q <= bus.pos_min_i);
    end
`endif
    pop_c       = issue_pop_c | limit_drop_c;
    push_ok_c   = rise_c && ((count < CNT_W'(DEPTH)) || pop_c);
    drop_c      = rise_c && !push_ok_c;
    count_nxt_c = count;
    if (push_ok_c && !pop_c) begin
      count_nxt_c = count + CNT_W'(1);
    end else if (!push_ok_c && pop_c) begin
      count_nxt_c = count - CNT_W'(1);
    end
    unique case (state)
      IDLE:    idle_nxt_c = empty_c || limit_drop_c;
      LOW:     idle_nxt_c = (timer == '0);
      default: idle_nxt_c = 1'b0;
    endcase
  end

  // Input synchronizers, step edge detect flop and bypass pipeline
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      step_s1  <= 1'b0;
      step_s2  <= 1'b0;
      step_s3  <= 1'b0;
      dir_s1   <= 1'b0;
      dir_s2   <= 1'b0;
      bypass_q <= 1'b0;
    end else begin
      step_s1  <= bus.step_i;
      step_s2  <= step_s1;
      step_s3  <= step_s2;
      dir_s1   <= bus.dir_i;
      dir_s2   <= dir_s1;
      bypass_q <= bus.bypass_i;
    end
  end

  // Direction FIFO; pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push_ok_c) begin
        fifo_mem[wr_ptr] <= dir_s2;
        wr_ptr           <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      count <= count_nxt_c;
    end
  end

  // Pulse sequencer: direction setup, step high, step low
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      timer  <= '0;
      step_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty_c && !limit_drop_c) begin
            if (head_c == dir_q) begin
              step_q <= 1'b1;
              timer  <= HIGH_LOAD;
              state  <= HIGH;
            end else begin
              dir_q <= head_c;
              timer <= SETUP_LOAD;
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          if (timer == '0) begin
            step_q <= 1'b1;
            timer  <= HIGH_LOAD;
            state  <= HIGH;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        HIGH: begin
          if (timer == '0) begin
            step_q <= 1'b0;
            timer  <= LOW_LOAD;
            state  <= LOW;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        LOW: begin
          if (timer == '0) begin
            state <= IDLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Position counter and sticky flags; clear wins over a same-cycle update
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      position_q  <= '0;
      overflow_q  <= 1'b0;
`ifdef STEP_PULSE_SHAPER_SOFT_LIMIT_EN
      limit_hit_q <= 1'b0;
`endif
    end else if (bus.clr_i) begin
      position_q  <= '0;
      overflow_q  <= 1'b0;
`ifdef STEP_PULSE_SHAPER_SOFT_LIMIT_EN
      limit_hit_q <= 1'b0;
`endif
    end else begin
      if (issue_pop_c) begin
        position_q <= head_c ? position_q + POS_WIDTH'(1)
                             : position_q - POS_WIDTH'(1);
      end
      if (drop_c) begin
        overflow_q <= 1'b1;
      end
`ifdef STEP_PULSE_SHAPER_SOFT_LIMIT_EN
      if (limit_drop_c) begin
        limit_hit_q <= 1'b1;
      end
`endif
    end
  end

  // Busy tracks next-cycle queue occupancy and FSM state so it is exact
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (count_nxt_c != '0) || !idle_nxt_c;
    end
  end

  assign bus.step_o     = step_q;
  assign bus.dir_o      = dir_q;
  assign bus.bypass_o   = bypass_q;
  assign bus.position_o = position_q;
  assign bus.pending_o  = count;
  assign bus.overflow_o = overflow_q;
  assign bus.busy_o     = busy_q;
`ifdef STEP_PULSE_SHAPER_SOFT_LIMIT_EN
  assign bus.limit_hit_o = limit_hit_q;
`endif

endmodule

// File: tb/tb_step_pulse_shaper.sv
// Directed bench for step_pulse_shaper: default timing instance (A) and a
// slow-pulse instance (B) used to fill the queue.
module tb_step_pulse_shaper;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  step_pulse_shaper_if #(.DEPTH_LOG2(3), .POS_WIDTH(32)) bus_a ();
  step_pulse_shaper_if #(.DEPTH_LOG2(3), .POS_WIDTH(32)) bus_b ();

  step_pulse_shaper #(
    .DEPTH_LOG2(3), .HIGH_CYC(4), .LOW_CYC(4), .DIR_SETUP(8), .POS_WIDTH(32)
  ) dut_a (.clk_i(clk), .reset_n(reset_n), .bus(bus_a));

  step_pulse_shaper #(
    .DEPTH_LOG2(3), .HIGH_CYC(20), .LOW_CYC(20), .DIR_SETUP(8), .POS_WIDTH(32)
  ) dut_b (.clk_i(clk), .reset_n(reset_n), .bus(bus_b));

  // Pulse monitors sampled on the falling edge
  logic mon_clear;
  int a_pulses, a_min_hi, a_max_hi, a_min_gap, a_last_setup, a_dir_hi_chg;
  int a_hi_len, a_lo_len, a_since_dir;
  logic a_prev_step, a_prev_dir, a_dir_pending;
  int b_pulses, b_peak;
  logic b_prev_step;

  always @(negedge clk) begin
    if (mon_clear) begin
      a_pulses = 0; a_min_hi = 1000; a_max_hi = 0; a_min_gap = 1000;
      a_last_setup = -1; a_dir_hi_chg = 0; a_hi_len = 0; a_lo_len = 1000;
      a_since_dir = 0; a_dir_pending = 1'b0;
      b_pulses = 0; b_peak = 0;
    end else begin
      if (bus_a.dir_o !== a_prev_dir) begin
        if (bus_a.step_o === 1'b1 || a_prev_step === 1'b1) a_dir_hi_chg++;
        a_dir_pending = 1'b1;
        a_since_dir = 0;
      end else begin
        a_since_dir++;
      end
      if (bus_a.step_o === 1'b1 && a_prev_step !== 1'b1) begin
        a_pulses++;
        if (a_lo_len < a_min_gap) a_min_gap = a_lo_len;
        if (a_dir_pending) begin
          a_last_setup = a_since_dir;
          a_dir_pending = 1'b0;
        end
        a_hi_len = 1;
      end else if (bus_a.step_o === 1'b1) begin
        a_hi_len++;
      end
      if (bus_a.step_o !== 1'b1 && a_prev_step === 1'b1) begin
        if (a_hi_len < a_min_hi) a_min_hi = a_hi_len;
        if (a_hi_len > a_max_hi) a_max_hi = a_hi_len;
        a_lo_len = 1;
      end else if (bus_a.step_o !== 1'b1) begin
        a_lo_len++;
      end
      if (bus_b.step_o === 1'b1 && b_prev_step !== 1'b1) b_pulses++;
      if (int'(bus_b.pending_o) > b_peak) b_peak = int'(bus_b.pending_o);
    end
    a_prev_step = bus_a.step_o;
    a_prev_dir  = bus_a.dir_o;
    b_prev_step = bus_b.step_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_a(input int n, input logic d);
    for (int i = 0; i < n; i++) begin
      bus_a.step_i = 1'b1; bus_a.dir_i = d; adv(1);
      bus_a.step_i = 1'b0; adv(1);
    end
  endtask

  task automatic pulse_b(input int n, input logic d);
    for (int i = 0; i < n; i++) begin
      bus_b.step_i = 1'b1; bus_b.dir_i = d; adv(1);
      bus_b.step_i = 1'b0; adv(1);
    end
  endtask

  task automatic clr_a();
    bus_a.clr_i = 1'b1; adv(1); bus_a.clr_i = 1'b0;
  endtask

  task automatic clear_mon();
    mon_clear = 1'b1; adv(1); mon_clear = 1'b0; adv(1);
  endtask

  task automatic wait_idle_a(input int budget, input string tag);
    int n = 0;
    adv(3);
    while (bus_a.busy_o !== 1'b0 && n < budget) begin adv(1); n++; end
    chk(tag, 64'(bus_a.busy_o), 64'd0);
  endtask

  task automatic wait_step_a(input int budget, input string tag);
    int n = 0;
    while (bus_a.step_o !== 1'b1 && n < budget) begin adv(1); n++; end
    chk(tag, 64'(bus_a.step_o), 64'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    mon_clear = 1'b1;
    bus_a.step_i = 1'b0; bus_a.dir_i = 1'b0; bus_a.bypass_i = 1'b0; bus_a.clr_i = 1'b0;
    bus_b.step_i = 1'b0; bus_b.dir_i = 1'b0; bus_b.bypass_i = 1'b0; bus_b.clr_i = 1'b0;
`ifdef STEP_PULSE_SHAPER_SOFT_LIMIT_EN
    bus_a.pos_max_i = 32'sh7fffffff; bus_a.pos_min_i = 32'sh80000000;
    bus_b.pos_max_i = 32'sh7fffffff; bus_b.pos_min_i = 32'sh80000000;
`endif
    adv(3);

    // Reset values
    chk("rst_step", 64'(bus_a.step_o), 64'd0);
    chk("rst_dir", 64'(bus_a.dir_o), 64'd0);
    chk("rst_bypass", 64'(bus_a.bypass_o), 64'd0);
    chk("rst_pos", 64'(bus_a.position_o), 64'd0);
    chk("rst_pending", 64'(bus_a.pending_o), 64'd0);
    chk("rst_ovf", 64'(bus_a.overflow_o), 64'd0);
    chk("rst_busy", 64'(bus_a.busy_o), 64'd0);
`ifdef STEP_PULSE_SHAPER_SOFT_LIMIT_EN
    chk("rst_limit", 64'(bus_a.limit_hit_o), 64'd0);
`endif
    reset_n = 1'b1;
    mon_clear = 1'b0;
    adv(2);

    // Single step with direction change: push on edge 3, setup 8, high 4
    bus_a.step_i = 1'b1; bus_a.dir_i = 1'b1;
    adv(3);
    bus_a.step_i = 1'b0;
    chk("t1_pending_e3", 64'(bus_a.pending_o), 64'd1);
    chk("t1_dir_e3", 64'(bus_a.dir_o), 64'd0);
    chk("t1_busy_e3", 64'(bus_a.busy_o), 64'd1);
    adv(1);
    chk("t1_dir_e4", 64'(bus_a.dir_o), 64'd1);
    adv(7);
    chk("t1_step_e11", 64'(bus_a.step_o), 64'd0);
    adv(1);
    chk("t1_step_e12", 64'(bus_a.step_o), 64'd1);
    adv(3);
    chk("t1_step_e15", 64'(bus_a.step_o), 64'd1);
    adv(1);
    chk("t1_step_e16", 64'(bus_a.step_o), 64'd0);
    chk("t1_pos_e16", 64'(bus_a.position_o), 64'd1);
    chk("t1_pending_e16", 64'(bus_a.pending_o), 64'd0);
    adv(3);
    chk("t1_busy_e19", 64'(bus_a.busy_o), 64'd1);
    adv(1);
    chk("t1_busy_e20", 64'(bus_a.busy_o), 64'd0);
    chk("t1_setup_len", 64'(a_last_setup), 64'd8);
    chk("t1_hi_len", 64'(a_max_hi), 64'd4);

    // Bypass is a one-cycle copy
    bus_a.bypass_i = 1'b1; adv(1);
    chk("bypass_hi", 64'(bus_a.bypass_o), 64'd1);
    bus_a.bypass_i = 1'b0; adv(1);
    chk("bypass_lo", 64'(bus_a.bypass_o), 64'd0);

    // Five back-to-back positive steps
    clr_a();
    chk("t2_clr_pos", 64'(bus_a.position_o), 64'd0);
    clear_mon();
    pulse_a(5, 1'b1);
    wait_idle_a(200, "t2_idle");
    chk("t2_pulses", 64'(a_pulses), 64'd5);
    chk("t2_min_hi", 64'(a_min_hi), 64'd4);
    chk("t2_max_hi", 64'(a_max_hi), 64'd4);
    chk("t2_min_gap", 64'(a_min_gap), 64'd5);
    chk("t2_pos", 64'(bus_a.position_o), 64'd5);
    chk("t2_ovf", 64'(bus_a.overflow_o), 64'd0);

    // Queue overflow on the slow instance: 8 accepted, 4 dropped
    clear_mon();
    pulse_b(12, 1'b1);
    begin
      int n = 0;
      adv(3);
      while (bus_b.busy_o !== 1'b0 && n < 1000) begin adv(1); n++; end
      chk("t3_idle", 64'(bus_b.busy_o), 64'd0);
    end
    chk("t3_peak", 64'(b_peak), 64'd8);
    chk("t3_ovf", 64'(bus_b.overflow_o), 64'd1);
    chk("t3_pulses", 64'(b_pulses), 64'd8);
    chk("t3_pos", 64'(bus_b.position_o), 64'd8);

    // +3 then -2 with a direction change in between
    clr_a();
    clear_mon();
    pulse_a(3, 1'b1);
    bus_a.dir_i = 1'b0;
    adv(2);
    pulse_a(2, 1'b0);
    wait_idle_a(300, "t4_idle");
    chk("t4_pulses", 64'(a_pulses), 64'd5);
    chk("t4_setup_len", 64'(a_last_setup), 64'd8);
    chk("t4_dir_while_high", 64'(a_dir_hi_chg), 64'd0);
    chk("t4_pos", 64'(bus_a.position_o), 64'd1);
    chk("t4_dir", 64'(bus_a.dir_o), 64'd0);

    // Reset asserted mid-pulse
    bus_a.dir_i = 1'b1;
    pulse_a(2, 1'b1);
    wait_step_a(50, "t5_step_seen");
    adv(1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_step", 64'(bus_a.step_o), 64'd0);
    chk("t5_rst_pending", 64'(bus_a.pending_o), 64'd0);
    adv(2);
    reset_n = 1'b1;
    clear_mon();
    adv(30);
    chk("t5_pulses", 64'(a_pulses), 64'd0);
    chk("t5_pos", 64'(bus_a.position_o), 64'd0);
    chk("t5_busy", 64'(bus_a.busy_o), 64'd0);

    // Clear coinciding with the HIGH->LOW pop at position 7
    pulse_a(7, 1'b1);
    wait_idle_a(400, "t6_idle7");
    chk("t6_pos7", 64'(bus_a.position_o), 64'd7);
    pulse_a(1, 1'b1);
    wait_step_a(50, "t6_step_seen");
    adv(3);
    chk("t6_step_last_hi", 64'(bus_a.step_o), 64'd1);
    bus_a.clr_i = 1'b1;
    adv(1);
    bus_a.clr_i = 1'b0;
    chk("t6_step_fell", 64'(bus_a.step_o), 64'd0);
    chk("t6_pos_clr", 64'(bus_a.position_o), 64'd0);
    wait_idle_a(50, "t6_idle");
    chk("t6_pos_after", 64'(bus_a.position_o), 64'd0);

`ifdef STEP_PULSE_SHAPER_SOFT_LIMIT_EN
    // Soft upper limit of 2 with four positive steps
    bus_a.pos_max_i = 32'sd2;
    clear_mon();
    pulse_a(4, 1'b1);
    wait_idle_a(300, "t7_idle");
    chk("t7_pos", 64'(bus_a.position_o), 64'd2);
    chk("t7_limit", 64'(bus_a.limit_hit_o), 64'd1);
    chk("t7_pulses", 64'(a_pulses), 64'd2);
    chk("t7_pending", 64'(bus_a.pending_o), 64'd0);
    clr_a();
    chk("t7_limit_clr", 64'(bus_a.limit_hit_o), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
